router_fifo: RTL
================

// Module: router_fifo
// PURPOSE
//  Per-destination output buffer fed by the router register stage: stores dout bytes
//  when the FSM asserts write_enb, tagging each entry with lfd_state so header bytes are known.
//  Drained by the destination client via read_enb.
//  Tracks packet length from each header so the client sees whole-packet completion.
//  Three instances sit between the register stage and the 1x3 output ports.
// PARAMETERS
//  WIDTH  8   data byte width (header length field fixed at bits [7:2])
//  DEPTH  16  entries; must be a power of 2
//  AW     4   log2(DEPTH)
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  soft_reset  in   1      sync flush from FSM timeout; same effect as reset on this block
//  write_enb   in   1      write request
//  lfd_state   in   1      current write byte is a header; stored as tag bit WIDTH
//  data_in     in   WIDTH  byte from register stage dout
//  read_enb    in   1      read request from destination client
//  data_out    out  WIDTH  registered read data
//  full        out  1      DEPTH entries held
//  empty       out  1      zero entries held
//  pkt_busy    out  1      packet partially read (pkt_cnt != 0)
//  pkt_done    out  1      one-cycle pulse: last (parity) byte of a packet read
// BEHAVIOUR
//  - Storage: DEPTH x (WIDTH+1) array; bit WIDTH = header tag.
//  - Pointers wr_ptr/rd_ptr are AW+1 bits.
//    empty = (wr_ptr == rd_ptr).
//    full = MSBs differ and low AW bits equal.
//    Pointers wrap naturally.
//  - Reset (priority 1) and soft_reset (priority 2), both synchronous: pointers = 0,
//    pkt_cnt = 0, data_out = 0, pkt_done = 0.
//    After the edge: empty = 1, full = 0, pkt_busy = 0.
//    A write or read in the same cycle is discarded. Memory contents need not clear.
//  - Write: accepted when write_enb && !full. Stores {lfd_state, data_in}; wr_ptr++.
//    Full is evaluated on the pre-edge value: a write while full is dropped even with a
//    concurrent read.
//  - Read: accepted when read_enb && !empty. data_out <= mem[rd_ptr][WIDTH-1:0]; rd_ptr++.
//    Latency: data_out is valid on the edge after read_enb is sampled.
//    A read while empty is ignored and data_out holds.
//  - data_out holds its last value between reads.
//  - Simultaneous read and write with 0 < count < DEPTH: both accepted; count unchanged.
//    Read on empty with a simultaneous write: only the write is accepted. No bypass.
//  - Packet counter pkt_cnt (7 bits), updated only on an accepted read:
//    - Tag = 1: pkt_cnt <= data[7:2] + 1 (payload plus parity byte).
//      A new header overrides any residual count.
//    - Tag = 0 and pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
//      pkt_done <= 1 when pkt_cnt == 1.
//    - Tag = 0 and pkt_cnt == 0: stray byte; counter unchanged, no pulse.
//  - pkt_done is a registered, one-cycle pulse, otherwise 0.
//  - Zero-payload header (len 0): pkt_cnt = 1; the next read (parity) pulses pkt_done.
// CONFIGURATION
//  ROUTER_FIFO_ALMOST_FLAGS_EN
//  - Defined: adds output ports almost_full (count >= DEPTH-1) and almost_empty (count <= 1).
//    Both are combinational from the pointers.
//    Reset/soft_reset values: almost_full = 0, almost_empty = 1.
//  - Undefined: ports absent; all other behaviour is identical.
// TESTING
//  - Reset → empty=1, full=0, data_out=0, pkt_busy=0, pkt_done=0.
//  - Write header 0x0D (len 3) + 3 payload + parity 0x5A, then read 5 →
//    data_out = 0x0D, then the payload bytes, then 0x5A.
//    pkt_busy = 1 from the first read to the last; pkt_done pulses on the 5th read only.
//  - Write 16 bytes → full = 1; a 17th write is dropped.
//    Read 16 → exact write order returned, empty = 1; pointers have wrapped.
//  - Full, then read_enb and write_enb together → read accepted, write dropped; full = 0 next.
//  - Write 6 bytes, read 2, assert soft_reset with write_enb = 1 →
//    empty = 1, data_out = 0, pkt_busy = 0; that write is not stored.
//  - Read while empty → data_out holds its previous value; rd_ptr unchanged.
//    With the macro defined: count 15 → almost_full = 1; count 1 → almost_empty = 1.

Source files
------------

// File: rtl/router_fifo.sv
// Per-destination router output FIFO with header tagging and packet-length tracking.
// Optional almost_full/almost_empty ports under ROUTER_FIFO_ALMOST_FLAGS_EN.
module router_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_busy,
  output logic             pkt_done
`ifdef ROUTER_FIFO_ALMOST_FLAGS_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 7;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    pkt_cnt, pkt_cnt_nxt;
  logic             pkt_done_nxt;
  logic             wr_acc, rd_acc;
  logic [WIDTH:0]   rd_entry;

  // Accept decisions use the pre-edge flags, so a write while full is dropped even with a read.
  always_comb begin
    wr_acc       = write_enb && !full;
    rd_acc       = read_enb && !empty;
    rd_entry     = mem[rd_ptr[AW-1:0]];
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    pkt_cnt_nxt  = pkt_cnt;
    pkt_done_nxt = 1'b0;
    if (wr_acc) wr_ptr_nxt = wr_ptr + PW'(1);
    if (rd_acc) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
      if (rd_entry[WIDTH]) begin
        // Header: payload length plus the trailing parity byte.
        pkt_cnt_nxt = CW'(rd_entry[7:2]) + CW'(1);
      end else if (pkt_cnt != '0) begin
        pkt_cnt_nxt  = pkt_cnt - CW'(1);
        pkt_done_nxt = (pkt_cnt == CW'(1));
      end
    end
  end

  // Pointers, read data and registered status flags.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
      pkt_done <= 1'b0;
      pkt_busy <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      pkt_cnt  <= pkt_cnt_nxt;
      pkt_done <= pkt_done_nxt;
      pkt_busy <= (pkt_cnt_nxt != '0);
      empty    <= (wr_ptr_nxt == rd_ptr_nxt);
      full     <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                  (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      if (rd_acc) data_out <= rd_entry[WIDTH-1:0];
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_acc && !reset && !soft_reset) mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  end

`ifdef ROUTER_FIFO_ALMOST_FLAGS_EN
  logic [AW:0] count;
  always_comb begin
    count        = wr_ptr - rd_ptr;
    almost_full  = (count >= PW'(DEPTH - 1));
    almost_empty = (count <= PW'(1));
  end
`endif

endmodule
